// File: rtl/frost32_mem_access_unit.sv
// Frost32 memory access unit: arbitrates core fetch and load/store requests onto
// a single-outstanding, registered main-memory bus and returns extended read data.
module frost32_mem_access_unit #(
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_done,
  output logic [31:0] fetch_data,
  input  logic        ls_valid,
  input  logic        ls_is_write,
  input  logic [1:0]  ls_size,
  input  logic        ls_sign_ext,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        req_mem_access,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        data_inout_access_type,
  output logic [1:0]  data_inout_access_size,
  input  logic [31:0] mem_data,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  localparam logic [1:0] DIAS32 = 2'd0;
  localparam logic [1:0] DIAS16 = 2'd1;
  localparam logic [1:0] DIAS8  = 2'd2;
  localparam logic       DIAT_READ  = 1'b0;
  localparam logic       DIAT_WRITE = 1'b1;

  state_t     state;
  logic [3:0] cnt;
  logic       src_ls;
  logic       sext;

  // Ready is gated by rst so that every output reads 0 while reset is held.
  assign ls_ready    = (state == ST_IDLE) && !rst;
  assign fetch_ready = ls_ready && !ls_valid;
  assign busy        = (state != ST_IDLE);

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sx);
    case (sz)
      DIAS32:  return d;
      DIAS16:  return {{16{sx & d[15]}}, d[15:0]};
      default: return {{24{sx & d[7]}}, d[7:0]};
    endcase
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      src_ls                 <= 1'b0;
      sext                   <= 1'b0;
      req_mem_access         <= 1'b0;
      addr                   <= '0;
      data                   <= '0;
      data_inout_access_type <= DIAT_READ;
      data_inout_access_size <= DIAS32;
      fetch_done             <= 1'b0;
      fetch_data             <= '0;
      ls_done                <= 1'b0;
      ls_rdata               <= '0;
    end else begin
      req_mem_access <= 1'b0;
      fetch_done     <= 1'b0;
      ls_done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The bus outputs double as the latched request; they hold until the next acceptance.
          if (ls_valid) begin
            src_ls                 <= 1'b1;
            sext                   <= ls_sign_ext;
            addr                   <= ls_addr;
            data                   <= ls_wdata;
            data_inout_access_type <= ls_is_write ? DIAT_WRITE : DIAT_READ;
            data_inout_access_size <= (ls_size == 2'd3) ? DIAS8 : ls_size;
            req_mem_access         <= 1'b1;
            state                  <= ST_ISSUE;
          end else if (fetch_valid) begin
            src_ls                 <= 1'b0;
            sext                   <= 1'b0;
            addr                   <= fetch_addr;
            data_inout_access_type <= DIAT_READ;
            data_inout_access_size <= DIAS32;
            req_mem_access         <= 1'b1;
            state                  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (data_inout_access_type == DIAT_WRITE) begin
            ls_done <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt   <= 4'(RESP_LATENCY);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          // The <= also covers an out-of-range zero latency, which would otherwise hang.
          if (cnt <= 4'd1) begin
            if (src_ls) begin
              ls_rdata <= extend(mem_data, data_inout_access_size, sext);
              ls_done  <= 1'b1;
            end else begin
              fetch_data <= mem_data;
              fetch_done <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frost32_mem_access_unit.sv
// Directed bench for frost32_mem_access_unit: two instances (latency 1 and 3),
// each with a big-endian byte-addressed memory model; table-driven vectors plus corner sequences.
module tb_frost32_mem_access_unit;

  localparam int LAT [2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic mem_init = 1'b1;

  logic        fetch_valid [2];
  logic [31:0] fetch_addr  [2];
  logic        fetch_ready [2];
  logic        fetch_done  [2];
  logic [31:0] fetch_data  [2];
  logic        ls_valid    [2];
  logic        ls_is_write [2];
  logic [1:0]  ls_size     [2];
  logic        ls_sign_ext [2];
  logic [31:0] ls_addr     [2];
  logic [31:0] ls_wdata    [2];
  logic        ls_ready    [2];
  logic        ls_done     [2];
  logic [31:0] ls_rdata    [2];
  logic        req         [2];
  logic [31:0] addr        [2];
  logic [31:0] data        [2];
  logic        dtype       [2];
  logic [1:0]  dsize       [2];
  logic        busy        [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  mem [1024];
    logic [31:0] mdata;
    logic [31:0] rword;
    logic [31:0] w;
    logic [9:0]  a;
    int unsigned pend;

    frost32_mem_access_unit #(.RESP_LATENCY(LAT[g])) u_dut (
      .clk                    (clk),
      .rst                    (rst),
      .fetch_valid            (fetch_valid[g]),
      .fetch_addr             (fetch_addr[g]),
      .fetch_ready            (fetch_ready[g]),
      .fetch_done             (fetch_done[g]),
      .fetch_data             (fetch_data[g]),
      .ls_valid               (ls_valid[g]),
      .ls_is_write            (ls_is_write[g]),
      .ls_size                (ls_size[g]),
      .ls_sign_ext            (ls_sign_ext[g]),
      .ls_addr                (ls_addr[g]),
      .ls_wdata               (ls_wdata[g]),
      .ls_ready               (ls_ready[g]),
      .ls_done                (ls_done[g]),
      .ls_rdata               (ls_rdata[g]),
      .req_mem_access         (req[g]),
      .addr                   (addr[g]),
      .data                   (data[g]),
      .data_inout_access_type (dtype[g]),
      .data_inout_access_size (dsize[g]),
      .mem_data               (mdata),
      .busy                   (busy[g])
    );

    // Responder: writes commit at the request edge; read data is valid LAT cycles after the request cycle.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        mem[10'h100] <= 8'h12; mem[10'h101] <= 8'h34;
        mem[10'h102] <= 8'h56; mem[10'h103] <= 8'h78;
        mem[10'h040] <= 8'h80; mem[10'h041] <= 8'h7F;
        mem[10'h042] <= 8'h80; mem[10'h043] <= 8'h01;
        mem[10'h202] <= 8'hA5; mem[10'h203] <= 8'h5A;
        mdata <= '0;
        rword <= '0;
        pend  <= 0;
      end else begin
        mdata <= 32'hBAD0_BAD0;
        if (pend != 0) begin
          pend <= pend - 1;
          if (pend == 1) mdata <= rword;
        end
        if (req[g]) begin
          a = addr[g][9:0];
          if (dtype[g]) begin
            case (dsize[g])
              2'd0: begin
                mem[a] <= data[g][31:24]; mem[a + 10'd1] <= data[g][23:16];
                mem[a + 10'd2] <= data[g][15:8]; mem[a + 10'd3] <= data[g][7:0];
              end
              2'd1: begin
                mem[a] <= data[g][15:8]; mem[a + 10'd1] <= data[g][7:0];
              end
              default: mem[a] <= data[g][7:0];
            endcase
          end else begin
            case (dsize[g])
              2'd0:    w = {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
              2'd1:    w = {16'h0, mem[a], mem[a + 10'd1]};
              default: w = {24'h0, mem[a]};
            endcase
            if (LAT[g] == 1) mdata <= w;
            else begin
              rword <= w;
              pend  <= LAT[g] - 1;
            end
          end
        end
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          dut;
    bit          is_ls;
    bit          wr;
    logic [1:0]  size;
    bit          sext;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_size;
    int          exp_lat;
  } vec_t;

  vec_t vecs [18];

  task automatic run_vec(input vec_t v);
    int d = v.dut;
    int lat = 0;
    @(negedge clk);
    if (v.is_ls) begin
      ls_valid[d] = 1'b1; ls_is_write[d] = v.wr; ls_size[d] = v.size;
      ls_sign_ext[d] = v.sext; ls_addr[d] = v.a; ls_wdata[d] = v.wd;
      #1 check({v.name, "_ls_ready"}, 32'(ls_ready[d]), 32'd1);
    end else begin
      fetch_valid[d] = 1'b1; fetch_addr[d] = v.a;
      #1 check({v.name, "_fetch_ready"}, 32'(fetch_ready[d]), 32'd1);
    end
    @(negedge clk);
    // Scramble the inputs: they must be ignored after acceptance.
    ls_valid[d] = 1'b0; fetch_valid[d] = 1'b0;
    ls_addr[d] = 32'hFFFF_FFFF; fetch_addr[d] = 32'hFFFF_FFFF; ls_wdata[d] = 32'h0;
    check({v.name, "_req"}, 32'(req[d]), 32'd1);
    check({v.name, "_addr"}, addr[d], v.a);
    check({v.name, "_type_size"}, {29'h0, dtype[d], dsize[d]}, {29'h0, v.wr, v.exp_size});
    if (v.wr) check({v.name, "_wdata"}, data[d], v.wd);
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (ls_done[d] || fetch_done[d]) begin
        lat = k;
        break;
      end
    end
    check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, "_done_src"}, {30'h0, ls_done[d], fetch_done[d]},
          v.is_ls ? 32'd2 : 32'd1);
    if (!v.wr) check({v.name, "_rdata"}, v.is_ls ? ls_rdata[d] : fetch_data[d], v.exp_rd);
    @(negedge clk);
    check({v.name, "_idle_after"}, {29'h0, ls_ready[d], busy[d], ls_done[d]}, 32'h4);
  endtask

  task automatic check_all_zero(input int d, input string tag);
    check({tag, "_req"}, 32'(req[d]), 32'd0);
    check({tag, "_addr"}, addr[d], 32'd0);
    check({tag, "_data"}, data[d], 32'd0);
    check({tag, "_ctl"}, {25'h0, dtype[d], dsize[d], busy[d], ls_ready[d], fetch_ready[d],
          ls_done[d] | fetch_done[d]}, 32'd0);
    check({tag, "_ls_rdata"}, ls_rdata[d], 32'd0);
    check({tag, "_fetch_data"}, fetch_data[d], 32'd0);
  endtask

  int n_ls, n_f, c_ls, c_f, n_req;

  initial begin
    vecs[0]  = '{"fetch100",  0, 0, 0, 2'd0, 0, 32'h100, 32'h0, 32'h12345678, 2'd0, 3};
    vecs[1]  = '{"lb_s40",    0, 1, 0, 2'd2, 1, 32'h040, 32'h0, 32'hFFFFFF80, 2'd2, 3};
    vecs[2]  = '{"lb_u40",    0, 1, 0, 2'd2, 0, 32'h040, 32'h0, 32'h00000080, 2'd2, 3};
    vecs[3]  = '{"lh_s42",    0, 1, 0, 2'd1, 1, 32'h042, 32'h0, 32'hFFFF8001, 2'd1, 3};
    vecs[4]  = '{"lh_u42",    0, 1, 0, 2'd1, 0, 32'h042, 32'h0, 32'h00008001, 2'd1, 3};
    vecs[5]  = '{"lw_40",     0, 1, 0, 2'd0, 1, 32'h040, 32'h0, 32'h807F8001, 2'd0, 3};
    vecs[6]  = '{"l3_s41",    0, 1, 0, 2'd3, 1, 32'h041, 32'h0, 32'h0000007F, 2'd2, 3};
    vecs[7]  = '{"sh_200",    0, 1, 1, 2'd1, 0, 32'h200, 32'hDEADBEEF, 32'h0, 2'd1, 2};
    vecs[8]  = '{"lw_200",    0, 1, 0, 2'd0, 0, 32'h200, 32'h0, 32'hBEEFA55A, 2'd0, 3};
    vecs[9]  = '{"sb_203",    0, 1, 1, 2'd2, 0, 32'h203, 32'h11223344, 32'h0, 2'd2, 2};
    vecs[10] = '{"lw_200b",   0, 1, 0, 2'd0, 0, 32'h200, 32'h0, 32'hBEEFA544, 2'd0, 3};
    vecs[11] = '{"fetch200",  0, 0, 0, 2'd0, 0, 32'h200, 32'h0, 32'hBEEFA544, 2'd0, 3};
    vecs[12] = '{"lh_s201",   0, 1, 0, 2'd1, 1, 32'h201, 32'h0, 32'hFFFFEFA5, 2'd1, 3};
    vecs[13] = '{"sw_204",    0, 1, 1, 2'd0, 0, 32'h204, 32'hCAFEF00D, 32'h0, 2'd0, 2};
    vecs[14] = '{"lb_s207",   0, 1, 0, 2'd2, 1, 32'h207, 32'h0, 32'h0000000D, 2'd2, 3};
    vecs[15] = '{"lb_s205",   0, 1, 0, 2'd2, 1, 32'h205, 32'h0, 32'hFFFFFFFE, 2'd2, 3};
    vecs[16] = '{"l3_fetch",  1, 0, 0, 2'd0, 0, 32'h100, 32'h0, 32'h12345678, 2'd0, 5};
    vecs[17] = '{"l3_lb_s40", 1, 1, 0, 2'd2, 1, 32'h040, 32'h0, 32'hFFFFFF80, 2'd2, 5};

    for (int d = 0; d < 2; d++) begin
      fetch_valid[d] = 0; fetch_addr[d] = 0; ls_valid[d] = 0; ls_is_write[d] = 0;
      ls_size[d] = 0; ls_sign_ext[d] = 0; ls_addr[d] = 0; ls_wdata[d] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero(0, "por");
    rst = 1'b0;
    mem_init = 1'b0;
    #1 check("por_release", {29'h0, ls_ready[0], fetch_ready[0], busy[0]}, 32'h6);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);
    check("store_mem200", {24'h0, g_dut[0].mem[10'h200]}, 32'hBE);
    check("store_mem201", {24'h0, g_dut[0].mem[10'h201]}, 32'hEF);

    // Arbitration: simultaneous requests, load/store wins, fetch follows.
    @(negedge clk);
    fetch_valid[0] = 1'b1; fetch_addr[0] = 32'h100;
    ls_valid[0] = 1'b1; ls_is_write[0] = 1'b0; ls_size[0] = 2'd2; ls_sign_ext[0] = 1'b0;
    ls_addr[0] = 32'h40;
    #1 check("arb_ready", {30'h0, ls_ready[0], fetch_ready[0]}, 32'h2);
    n_ls = 0; n_f = 0; c_ls = 0; c_f = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ls_valid[0] = 1'b0;
      if (k == 1) check("arb_ls_issue", {req[0], addr[0][30:0]}, 32'h8000_0040);
      else if (req[0]) begin
        check("arb_fetch_issue_cycle", 32'(k), 32'd5);
        check("arb_fetch_addr", addr[0], 32'h100);
        fetch_valid[0] = 1'b0;
      end
      if (ls_done[0]) begin n_ls++; c_ls = k; end
      if (fetch_done[0]) begin n_f++; c_f = k; end
    end
    fetch_valid[0] = 1'b0;
    check("arb_ls_done_cnt", 32'(n_ls), 32'd1);
    check("arb_fetch_done_cnt", 32'(n_f), 32'd1);
    check("arb_ls_done_cycle", 32'(c_ls), 32'd3);
    check("arb_fetch_done_cycle", 32'(c_f), 32'd7);
    check("arb_ls_rdata", ls_rdata[0], 32'h80);
    check("arb_fetch_data", fetch_data[0], 32'h12345678);

    // Asynchronous reset mid-cycle while a request is on the bus.
    @(negedge clk);
    ls_valid[0] = 1'b1; ls_is_write[0] = 1'b0; ls_size[0] = 2'd0; ls_addr[0] = 32'h100;
    @(negedge clk);
    ls_valid[0] = 1'b0;
    check("mid_req_before", 32'(req[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero(0, "mid_rst");
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_release", {29'h0, ls_ready[0], fetch_ready[0], busy[0]}, 32'h6);
    n_ls = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ls_done[0] || fetch_done[0] || req[0]) n_ls++;
    end
    check("mid_no_activity", 32'(n_ls), 32'd0);
    run_vec(vecs[0]);

    run_vec(vecs[16]);
    run_vec(vecs[17]);

    // Reset during WAIT on the latency-3 instance.
    @(negedge clk);
    ls_valid[1] = 1'b1; ls_is_write[1] = 1'b0; ls_size[1] = 2'd2; ls_sign_ext[1] = 1'b1;
    ls_addr[1] = 32'h40;
    @(negedge clk);
    ls_valid[1] = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", {30'h0, busy[1], req[1]}, 32'h2);
    #2 rst = 1'b1;
    #1 check("abort_rst_ctl", {29'h0, req[1], busy[1], ls_done[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_ls = 0; n_req = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ls_done[1] || fetch_done[1]) n_ls++;
      if (req[1]) n_req++;
    end
    check("abort_no_done", 32'(n_ls), 32'd0);
    check("abort_no_req", 32'(n_req), 32'd0);
    run_vec(vecs[16]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
